// File: rtl/ascon_rx_deframer_pkg.sv
// Shared definitions for the ASCON receive deframer.
//   - FSM state encodings (3-bit constants)
//   - fixed nonce / tag sizes
//   - frame_bytes(): total frame length in bytes for given AD / CT widths
package ascon_rx_deframer_pkg;

  localparam int NONCE_BYTES = 16;
  localparam int TAG_BYTES   = 16;

  localparam logic [2:0] ST_RX_NONCE  = 3'd0;
  localparam logic [2:0] ST_RX_AD     = 3'd1;
  localparam logic [2:0] ST_RX_CT     = 3'd2;
  localparam logic [2:0] ST_RX_TAG    = 3'd3;
  localparam logic [2:0] ST_START     = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  function automatic int frame_bytes(input int l_bits, input int y_bits);
    return NONCE_BYTES + l_bits / 8 + y_bits / 8 + TAG_BYTES;
  endfunction

endpackage

// File: rtl/ascon_byte_shifter.sv
// Field register fed a byte at a time: each load shifts the register left
// by one byte and drops din into the low byte, so the first byte received
// ends up in the MSBs once W/8 bytes have arrived.
//   clk, rst  - clock, async active-low reset (clears q)
//   load      - shift din in this cycle
//   din       - incoming byte
//   q         - field contents
module ascon_byte_shifter #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [7:0]   din,
  output logic [W-1:0] q
);

  generate
    if (W == 8) begin : g_byte
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (load) q <= din;
      end
    end else begin : g_wide
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (load) q <= {q[W-9:0], din};
      end
    end
  endgenerate

endmodule

// File: rtl/ascon_rx_deframer.sv
// Receive-side deframer for an ASCON decryption core.
// Collects nonce | AD | CT | tag from a byte stream, launches the core with
// a one-cycle dec_start, then waits (bounded by TIMEOUT) for the core result.
//   clk, rst               - clock, async active-low reset
//   rx_data/valid/last     - byte stream in; rx_ready back-pressure out
//   nonce/associated_data/cipher_text/tag - assembled fields, first byte MSB
//   dec_start              - launch pulse to the core
//   decryption_done, message_authenticated - core result
//   auth_valid, auth_pass  - result pulse / latched pass flag
//   frame_err              - pulse on bad rx_last placement or core timeout
module ascon_rx_deframer
  import ascon_rx_deframer_pkg::*;
#(
  parameter int L       = 40,
  parameter int Y       = 40,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic           rx_last,
  output logic           rx_ready,
  output logic [127:0]   nonce,
  output logic [L-1:0]   associated_data,
  output logic [Y-1:0]   cipher_text,
  output logic [127:0]   tag,
  output logic           dec_start,
  input  logic           decryption_done,
  input  logic           message_authenticated,
  output logic           auth_valid,
  output logic           auth_pass,
  output logic           frame_err
);

  localparam int N  = frame_bytes(L, Y);
  localparam int CW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] IDX_NONCE_END = CW'(NONCE_BYTES - 1);
  localparam logic [CW-1:0] IDX_AD_END    = CW'(NONCE_BYTES + L/8 - 1);
  localparam logic [CW-1:0] IDX_CT_END    = CW'(NONCE_BYTES + L/8 + Y/8 - 1);
  localparam logic [CW-1:0] IDX_LAST      = CW'(N - 1);
  localparam logic [WW-1:0] WAIT_LAST     = WW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic          rx_state;
  logic          acc;
  logic          at_last;

  assign rx_state = (state == ST_RX_NONCE) || (state == ST_RX_AD) ||
                    (state == ST_RX_CT)    || (state == ST_RX_TAG);
  // Gated by the reset pin so ready is low while reset is held and rises
  // as soon as it is released.
  assign rx_ready  = rx_state & rst;
  assign acc       = rx_valid & rx_ready;
  assign at_last   = (cnt == IDX_LAST);
  assign dec_start = (state == ST_START);

  ascon_byte_shifter #(.W(128)) u_nonce (
    .clk(clk), .rst(rst), .load(acc && state == ST_RX_NONCE), .din(rx_data), .q(nonce)
  );
  ascon_byte_shifter #(.W(L)) u_ad (
    .clk(clk), .rst(rst), .load(acc && state == ST_RX_AD), .din(rx_data), .q(associated_data)
  );
  ascon_byte_shifter #(.W(Y)) u_ct (
    .clk(clk), .rst(rst), .load(acc && state == ST_RX_CT), .din(rx_data), .q(cipher_text)
  );
  ascon_byte_shifter #(.W(128)) u_tag (
    .clk(clk), .rst(rst), .load(acc && state == ST_RX_TAG), .din(rx_data), .q(tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RX_NONCE;
      cnt        <= '0;
      wcnt       <= '0;
      auth_valid <= 1'b0;
      auth_pass  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      auth_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_RX_NONCE, ST_RX_AD, ST_RX_CT, ST_RX_TAG: begin
          if (acc) begin
            // rx_last must coincide exactly with the final byte index.
            if (rx_last != at_last) begin
              frame_err <= 1'b1;
              state     <= ST_RX_NONCE;
              cnt       <= '0;
            end else if (at_last) begin
              state <= ST_START;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == IDX_NONCE_END)   state <= ST_RX_AD;
              else if (cnt == IDX_AD_END) state <= ST_RX_CT;
              else if (cnt == IDX_CT_END) state <= ST_RX_TAG;
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT_DONE;
          wcnt  <= '0;
        end
        ST_WAIT_DONE: begin
          // A done arriving in the final allowed wait cycle still wins.
          if (decryption_done) begin
            auth_pass  <= message_authenticated;
            auth_valid <= 1'b1;
            state      <= ST_RX_NONCE;
          end else if (wcnt == WAIT_LAST) begin
            frame_err <= 1'b1;
            state     <= ST_RX_NONCE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= ST_RX_NONCE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_rx_deframer.sv
module tb_ascon_rx_deframer;

  localparam int L  = 40;
  localparam int Y  = 40;
  localparam int TO = 255;
  localparam int AB = L / 8;
  localparam int CB = Y / 8;
  localparam int N  = 16 + AB + CB + 16;

  logic           clk, rst;
  logic [7:0]     rx_data;
  logic           rx_valid, rx_last, rx_ready;
  logic [127:0]   nonce, tag;
  logic [L-1:0]   associated_data;
  logic [Y-1:0]   cipher_text;
  logic           dec_start, decryption_done, message_authenticated;
  logic           auth_valid, auth_pass, frame_err;

  ascon_rx_deframer #(.L(L), .Y(Y), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .rx_ready(rx_ready), .nonce(nonce), .associated_data(associated_data),
    .cipher_text(cipher_text), .tag(tag), .dec_start(dec_start),
    .decryption_done(decryption_done), .message_authenticated(message_authenticated),
    .auth_valid(auth_valid), .auth_pass(auth_pass), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Behavioural model: phase 0 = collecting bytes, 1 = launch cycle, 2 = awaiting core.
  int           m_phase, m_idx, m_wait;
  bit           m_in_rst, m_av, m_fe, m_pass;
  logic [127:0] m_nonce, m_tag;
  logic [L-1:0] m_ad;
  logic [Y-1:0] m_ct;
  logic [7:0]   fr [N];

  task automatic chk1(input string nm, input logic a, input logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_in_rst = 1; m_phase = 0; m_idx = 0; m_wait = 0;
    m_av = 0; m_fe = 0; m_pass = 0;
    m_nonce = '0; m_tag = '0; m_ad = '0; m_ct = '0;
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit l,
                              input bit dn, input bit ma);
    m_av = 0; m_fe = 0;
    case (m_phase)
      0: if (v) begin
        if (m_idx < 16)                m_nonce = {m_nonce[119:0], d};
        else if (m_idx < 16 + AB)      m_ad    = {m_ad[L-9:0], d};
        else if (m_idx < 16 + AB + CB) m_ct    = {m_ct[Y-9:0], d};
        else                           m_tag   = {m_tag[119:0], d};
        if (l != (m_idx == N - 1)) begin m_fe = 1; m_idx = 0; end
        else if (m_idx == N - 1)   begin m_phase = 1; m_idx = 0; end
        else m_idx++;
      end
      1: begin m_phase = 2; m_wait = 0; end
      default: begin
        if (dn) begin m_pass = ma; m_av = 1; m_phase = 0; end
        else begin
          m_wait++;
          if (m_wait == TO) begin m_fe = 1; m_phase = 0; end
        end
      end
    endcase
  endtask

  task automatic check();
    chk1("rx_ready",   rx_ready,   !m_in_rst && m_phase == 0);
    chk1("dec_start",  dec_start,  !m_in_rst && m_phase == 1);
    chk1("auth_valid", auth_valid, m_av);
    chk1("auth_pass",  auth_pass,  m_pass);
    chk1("frame_err",  frame_err,  m_fe);
    chkw("nonce", nonce, m_nonce);
    chkw("assoc_data", 128'(associated_data), 128'(m_ad));
    chkw("cipher_text", 128'(cipher_text), 128'(m_ct));
    chkw("tag", tag, m_tag);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit dn, input bit ma);
    rx_valid = v; rx_data = d; rx_last = l; decryption_done = dn; message_authenticated = ma;
    model_update(v, d, l, dn, ma);
    @(posedge clk); @(negedge clk);
    check();
  endtask

  task automatic load_fixed();
    logic [127:0] nv, tv;
    logic [39:0]  av, cv;
    nv = 128'h0123456789ABCDEF0123456789ABCDEF;
    tv = 128'h000102030405060708090A0B0C0D0E0F;
    av = 40'h0123456789;
    cv = 40'h1122334455;
    for (int i = 0; i < 16; i++) fr[i] = nv[127-8*i -: 8];
    for (int i = 0; i < AB; i++) fr[16+i] = av[39-8*i -: 8];
    for (int i = 0; i < CB; i++) fr[16+AB+i] = cv[39-8*i -: 8];
    for (int i = 0; i < 16; i++) fr[16+AB+CB+i] = tv[127-8*i -: 8];
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
  endtask

  function automatic bit in_ct(input int i);
    return (i >= 16 + AB) && (i < 16 + AB + CB);
  endfunction

  // last_at: byte index carrying rx_last (-1: none); bytes after stop_after are not sent.
  task automatic send_frame(input int last_at, input int stop_after, input int maxgap, input bit spur);
    for (int i = 0; i < N && i <= stop_after; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++)
        step(0, 8'($urandom), 0, spur && in_ct(i) && ($urandom_range(1, 0) == 1), 0);
      step(1, fr[i], i == last_at, spur && in_ct(i), 0);
      if (i == last_at) break;
    end
  endtask

  task automatic respond(input int delay, input bit give, input bit ma);
    for (int k = 0; k < delay; k++) step(0, 8'h00, 0, 0, 0);
    if (give) step(0, 8'h00, 0, 1, ma);
  endtask

  // Literal expectations for the fixed frame, checked in the launch cycle.
  task automatic pin_fixed();
    chk1("pin_dec_start", dec_start, 1'b1);
    chk1("pin_rx_ready_low", rx_ready, 1'b0);
    chkw("pin_nonce", nonce, 128'h0123456789ABCDEF0123456789ABCDEF);
    chkw("pin_ad", 128'(associated_data), 128'h0123456789);
    chkw("pin_ct", 128'(cipher_text), 128'h1122334455);
    chkw("pin_tag", tag, 128'h000102030405060708090A0B0C0D0E0F);
  endtask

  task automatic do_reset(input int cycles);
    rst = 0; rx_valid = 0; rx_data = 0; rx_last = 0;
    decryption_done = 0; message_authenticated = 0;
    model_reset();
    #1 check();
    for (int k = 0; k < cycles; k++) begin @(negedge clk); check(); end
    rst = 1; m_in_rst = 0;
    #1 check();
  endtask

  initial begin
    rst = 0;
    do_reset(3);
    chk1("pin_ready_after_reset", rx_ready, 1'b1);

    // Fixed frame, result three cycles after launch, pass.
    load_fixed();
    send_frame(N - 1, N, 0, 0);
    pin_fixed();
    respond(3, 1, 1);
    chk1("pin_auth_valid", auth_valid, 1'b1);
    chk1("pin_auth_pass", auth_pass, 1'b1);

    // Back-to-back second frame, result fail.
    send_frame(N - 1, N, 0, 0);
    pin_fixed();
    respond(5, 1, 0);
    chk1("pin_auth_pass_fail", auth_pass, 1'b0);

    // rx_last on byte 20, then a good frame.
    send_frame(20, N, 0, 0);
    chk1("pin_early_last_err", frame_err, 1'b1);
    send_frame(N - 1, N, 0, 0);
    pin_fixed();
    respond(2, 1, 1);

    // Missing rx_last on the final byte.
    send_frame(-1, N, 0, 0);
    chk1("pin_missing_last_err", frame_err, 1'b1);

    // Core never answers.
    send_frame(N - 1, N, 0, 0);
    respond(TO + 4, 0, 0);

    // Reset after byte 30, then a fresh frame.
    send_frame(N - 1, 30, 0, 0);
    do_reset(2);
    send_frame(N - 1, N, 0, 0);
    pin_fixed();
    respond(1, 1, 1);

    // Gaps plus spurious done during CT.
    send_frame(N - 1, N, 5, 1);
    pin_fixed();
    respond(4, 1, 1);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      int r;
      load_random();
      r = int'($urandom_range(7, 0));
      if (r == 0)      send_frame(int'($urandom_range(N - 2, 0)), N, 3, 1);
      else if (r == 1) send_frame(-1, N, 3, 0);
      else begin
        send_frame(N - 1, N, int'($urandom_range(3, 0)), r == 2);
        respond(int'($urandom_range(12, 1)), 1, $urandom_range(1, 0) == 1);
      end
    end
    respond(3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
